// File: rtl/onewire_pkg.sv
// Shared constants for the 1-Wire master: register map, command codes,
// STATUS bit positions, FSM encoding and default bus timing (in microseconds).
package onewire_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CMD    = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;

  localparam logic [2:0] CMD_RESET  = 3'd1;
  localparam logic [2:0] CMD_WRBIT  = 3'd2;
  localparam logic [2:0] CMD_RDBIT  = 3'd3;
  localparam logic [2:0] CMD_WRBYTE = 3'd4;
  localparam logic [2:0] CMD_RDBYTE = 3'd5;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_PRESENCE = 2;
  localparam int STAT_ERR      = 3;

  localparam int DEF_US_DIV = 50;
  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_RSTH = 480;
  localparam int DEF_T_MSP  = 70;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_MSR  = 15;
  localparam int DEF_T_SLOT = 70;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_SLOT_LOW,
    ST_SLOT_REL,
    ST_DONE
  } ow_state_e;

  function automatic logic cmd_valid(input logic [2:0] code);
    return (code >= CMD_RESET) && (code <= CMD_RDBYTE);
  endfunction

endpackage

// File: rtl/onewire_tick.sv
// Microsecond prescaler: one-cycle us_tick every US_DIV clocks, phase reset
// by a synchronous restart so a new command starts on a whole microsecond.
module onewire_tick #(
  parameter int US_DIV = 50
) (
  input  logic csi_clk,
  input  logic csi_reset,
  input  logic restart,
  output logic us_tick
);

  localparam int CW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset)
      div_cnt <= '0;
    else if (restart || div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign us_tick = (div_cnt == LAST) && !restart;

endmodule

// File: rtl/onewire_master.sv
// Avalon-MM 1-Wire bus master: software issues reset/bit/byte commands and the
// FSM times the open-drain pin in microseconds, raising done when finished.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int US_DIV = DEF_US_DIV,
  parameter int T_RSTL = DEF_T_RSTL,
  parameter int T_RSTH = DEF_T_RSTH,
  parameter int T_MSP  = DEF_T_MSP,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_MSR  = DEF_T_MSR,
  parameter int T_SLOT = DEF_T_SLOT
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic [2:0]  avs_s1_address,
  input  logic        chipselect,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  output logic        ins_irq,
  inout  wire         coe_bit
);

  localparam logic [9:0] RSTL_US   = 10'(T_RSTL);
  localparam logic [9:0] RSTH_US   = 10'(T_RSTH);
  localparam logic [9:0] PRES_AT   = 10'(T_MSP - 1);
  localparam logic [9:0] LOW1_US   = 10'(T_LOW1);
  localparam logic [9:0] LOW0_US   = 10'(T_LOW0);
  localparam logic [9:0] SAMPLE_AT = 10'(T_MSR - T_LOW1 - 1);
  localparam logic [9:0] SLOT_US   = 10'(T_SLOT);

  ow_state_e   state, state_next;
  logic [9:0]  us_cnt, low_len, rel_len;
  logic [7:0]  tx, rx;
  logic [3:0]  bit_cnt;
  logic [2:0]  cmd_q;
  logic [31:0] rd_mux;
  logic busy, done, err, presence, irq_en;
  logic pull_low_q, pin_meta, pin_sync, us_tick;
  logic wr_en, cmd_start, is_read, cur_bit;
  logic pull_low_d, sample_presence, sample_rx, slot_end, finish;
  logic wdata_unused;

  assign wdata_unused = ^avs_s1_writedata[31:8];
  assign wr_en     = chipselect & avs_s1_write;
  assign cmd_start = wr_en && (avs_s1_address == ADDR_CMD) && !busy
                     && cmd_valid(avs_s1_writedata[2:0]);

  assign is_read = (cmd_q == CMD_RDBIT) || (cmd_q == CMD_RDBYTE);
  assign cur_bit = is_read | tx[0];
  assign low_len = cur_bit ? LOW1_US : LOW0_US;
  assign rel_len = SLOT_US - low_len;

  onewire_tick #(.US_DIV(US_DIV)) u_tick (
    .csi_clk   (csi_clk),
    .csi_reset (csi_reset),
    .restart   (cmd_start),
    .us_tick   (us_tick)
  );

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (busy) state_next = (cmd_q == CMD_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
      ST_RST_LOW:  if (us_cnt == RSTL_US) state_next = ST_RST_HIGH;
      ST_RST_HIGH: if (us_cnt == RSTH_US) state_next = ST_DONE;
      ST_SLOT_LOW: if (us_cnt == low_len) state_next = ST_SLOT_REL;
      ST_SLOT_REL: if (us_cnt == rel_len)
                     state_next = (bit_cnt == 4'd1) ? ST_DONE : ST_SLOT_LOW;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Pin drive follows the state being entered so it lines up with the state flop.
  always_comb begin
    pull_low_d      = (state_next == ST_RST_LOW) || (state_next == ST_SLOT_LOW);
    sample_presence = 1'b0;
    sample_rx       = 1'b0;
    slot_end        = 1'b0;
    finish          = 1'b0;
    case (state)
      ST_RST_HIGH: sample_presence = us_tick && (us_cnt == PRES_AT);
      ST_SLOT_REL: begin
        sample_rx = is_read && us_tick && (us_cnt == SAMPLE_AT);
        slot_end  = (us_cnt == rel_len);
      end
      ST_DONE:     finish = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (avs_s1_address)
      ADDR_DATA:   rd_mux = {24'd0, rx};
      ADDR_STATUS: rd_mux = {28'd0, err, presence, done, busy};
      ADDR_CTRL:   rd_mux = {31'd0, irq_en};
      default:     rd_mux = '0;
    endcase
  end

  // Register writes come first so a DONE in the same cycle wins over a done-clear.
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      pin_meta <= 1'b0;  pin_sync <= 1'b0;  pull_low_q <= 1'b0;
      us_cnt <= '0;  tx <= '0;  rx <= '0;  bit_cnt <= '0;  cmd_q <= '0;
      busy <= 1'b0;  done <= 1'b0;  err <= 1'b0;  presence <= 1'b0;  irq_en <= 1'b0;
      avs_s1_readdata <= '0;
    end else begin
      pin_meta   <= coe_bit;
      pin_sync   <= pin_meta;
      pull_low_q <= pull_low_d;
      avs_s1_readdata <= rd_mux;

      if (state_next != state || state == ST_IDLE)
        us_cnt <= '0;
      else if (us_tick)
        us_cnt <= us_cnt + 1'b1;

      if (sample_presence) presence <= ~pin_sync;
      if (sample_rx)       rx <= {pin_sync, rx[7:1]};
      if (slot_end) begin
        tx      <= {1'b0, tx[7:1]};
        bit_cnt <= bit_cnt - 1'b1;
      end

      if (wr_en) begin
        case (avs_s1_address)
          ADDR_DATA:
            if (busy) err <= 1'b1;
            else      tx  <= avs_s1_writedata[7:0];
          ADDR_CMD:
            if (busy) err <= 1'b1;
            else if (cmd_start) begin
              busy    <= 1'b1;
              done    <= 1'b0;
              cmd_q   <= avs_s1_writedata[2:0];
              bit_cnt <= (avs_s1_writedata[2:0] == CMD_WRBYTE ||
                          avs_s1_writedata[2:0] == CMD_RDBYTE) ? 4'd8 : 4'd1;
            end
          ADDR_STATUS: begin
            if (avs_s1_writedata[STAT_DONE]) done <= 1'b0;
            if (avs_s1_writedata[STAT_ERR])  err  <= 1'b0;
          end
          ADDR_CTRL: irq_en <= avs_s1_writedata[0];
          default: ;
        endcase
      end

      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign ins_irq = done & irq_en;
  assign coe_bit = pull_low_q ? 1'b0 : 1'bz;

endmodule
